alarm_setter: RTL and testbench

Alarm-time entry stage feeding the clock wrapper's `alarm_hours` / `alarm_minutes` inputs. When the mode selector is in alarm mode, the user edits a working copy of the alarm time with set/up/down pulses. The copy is committed to the alarm outputs only on completion of the edit sequence. The block also drives six 7-segment digits showing the alarm time, blinking the field under edit at the `real_quarter` rate.

---
 rtl/alarm_setter.sv | 158 +++++++++++++++
 tb/tb_alarm_setter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_setter.sv
// alarm_setter: alarm-time entry with set/up/down editing and commit.
// Drives committed alarm time plus six blinking 7-segment digits.
module alarm_setter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] currentMode,
    input  logic       real_quarter,
    input  logic       pulsed_set,
    input  logic       pulsed_up,
    input  logic       pulsed_down,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic [6:0] disp0,
    output logic [6:0] disp1,
    output logic [6:0] disp2,
    output logic [6:0] disp3,
    output logic [6:0] disp4,
    output logic [6:0] disp5,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } st_t;

    st_t        st_q, st_d;
    logic [4:0] work_h, work_h_d, alarm_h_d;
    logic [5:0] work_m, work_m_d, alarm_m_d;
    logic       active;

    assign active = (currentMode == 2'd1);
    assign state  = st_q;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    endfunction

    // State, working copy and committed alarm registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q          <= IDLE;
            work_h        <= 5'd0;
            work_m        <= 6'd0;
            alarm_hours   <= 5'd0;
            alarm_minutes <= 6'd0;
        end else begin
            st_q          <= st_d;
            work_h        <= work_h_d;
            work_m        <= work_m_d;
            alarm_hours   <= alarm_h_d;
            alarm_minutes <= alarm_m_d;
        end
    end

    // Next state: leaving mode 1 aborts; set beats up, up beats down.
    always_comb begin
        st_d      = st_q;
        work_h_d  = work_h;
        work_m_d  = work_m;
        alarm_h_d = alarm_hours;
        alarm_m_d = alarm_minutes;
        if (!active || st_q == IDLE) begin
            st_d     = IDLE;
            work_h_d = alarm_hours;
            work_m_d = alarm_minutes;
            if (active && pulsed_set)
                st_d = SET_HOUR;
        end else begin
            unique case (st_q)
                SET_HOUR: begin
                    if (pulsed_set)
                        st_d = SET_MIN;
                    else if (pulsed_up)
                        work_h_d = (work_h == 5'd23) ? 5'd0 : work_h + 5'd1;
                    else if (pulsed_down)
                        work_h_d = (work_h == 5'd0) ? 5'd23 : work_h - 5'd1;
                end
                SET_MIN: begin
                    if (pulsed_set) begin
                        st_d      = IDLE;
                        alarm_h_d = work_h;
                        alarm_m_d = work_m;
                    end else if (pulsed_up)
                        work_m_d = (work_m == 6'd59) ? 6'd0 : work_m + 6'd1;
                    else if (pulsed_down)
                        work_m_d = (work_m == 6'd0) ? 6'd59 : work_m - 6'd1;
                end
                default: st_d = IDLE;
            endcase
        end
    end

    logic [4:0] sh, hu5;
    logic [5:0] sm, mu6;
    logic [3:0] ht, mt;

    // Split the shown value into tens/units by range compares.
    always_comb begin
        sh = (st_q == IDLE) ? alarm_hours : work_h;
        sm = (st_q == IDLE) ? alarm_minutes : work_m;
        ht = 4'd0;
        hu5 = sh;
        if (sh >= 5'd20) begin
            ht  = 4'd2;
            hu5 = sh - 5'd20;
        end else if (sh >= 5'd10) begin
            ht  = 4'd1;
            hu5 = sh - 5'd10;
        end
        mt  = 4'd0;
        mu6 = sm;
        if (sm >= 6'd50) begin
            mt  = 4'd5;
            mu6 = sm - 6'd50;
        end else if (sm >= 6'd40) begin
            mt  = 4'd4;
            mu6 = sm - 6'd40;
        end else if (sm >= 6'd30) begin
            mt  = 4'd3;
            mu6 = sm - 6'd30;
        end else if (sm >= 6'd20) begin
            mt  = 4'd2;
            mu6 = sm - 6'd20;
        end else if (sm >= 6'd10) begin
            mt  = 4'd1;
            mu6 = sm - 6'd10;
        end
    end

    logic blank_h, blank_m;
    assign blank_h = (st_q == SET_HOUR) && !real_quarter;
    assign blank_m = (st_q == SET_MIN) && !real_quarter;

    // Segment drive with the edited field blanked on the dark phase.
    always_comb begin
        disp0 = blank_h ? 7'b0000000 : seg(ht);
        disp1 = blank_h ? 7'b0000000 : seg(hu5[3:0]);
        disp2 = blank_m ? 7'b0000000 : seg(mt);
        disp3 = blank_m ? 7'b0000000 : seg(mu6[3:0]);
        disp4 = seg(4'd0);
        disp5 = seg(4'd0);
    end

endmodule

// File: tb/tb_alarm_setter.sv
// tb_alarm_setter: directed checks of alarm_setter entry, wrap,
// abort, blink, priority and asynchronous reset.
module tb_alarm_setter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] currentMode;
    logic       real_quarter;
    logic       pulsed_set, pulsed_up, pulsed_down;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    localparam logic [6:0] Z  = 7'b1111110;
    localparam logic [6:0] BL = 7'b0000000;
    localparam logic [6:0] SEG [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    alarm_setter dut (
        .clk(clk),
        .reset(reset),
        .currentMode(currentMode),
        .real_quarter(real_quarter),
        .pulsed_set(pulsed_set),
        .pulsed_up(pulsed_up),
        .pulsed_down(pulsed_down),
        .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes),
        .disp0(disp0),
        .disp1(disp1),
        .disp2(disp2),
        .disp3(disp3),
        .disp4(disp4),
        .disp5(disp5),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag,
                            input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
        chk({tag, ".d0"}, {9'd0, disp0}, {9'd0, e0});
        chk({tag, ".d1"}, {9'd0, disp1}, {9'd0, e1});
        chk({tag, ".d2"}, {9'd0, disp2}, {9'd0, e2});
        chk({tag, ".d3"}, {9'd0, disp3}, {9'd0, e3});
        chk({tag, ".d4"}, {9'd0, disp4}, {9'd0, Z});
        chk({tag, ".d5"}, {9'd0, disp5}, {9'd0, Z});
    endtask

    task automatic chk_alarm(input string tag, input int h, input int m);
        chk({tag, ".ah"}, {11'd0, alarm_hours}, h[15:0]);
        chk({tag, ".am"}, {10'd0, alarm_minutes}, m[15:0]);
    endtask

    task automatic step(input logic s, input logic u, input logic d);
        @(negedge clk);
        pulsed_set  = s;
        pulsed_up   = u;
        pulsed_down = d;
        @(posedge clk);
        #1;
        pulsed_set  = 1'b0;
        pulsed_up   = 1'b0;
        pulsed_down = 1'b0;
    endtask

    task automatic rep(input logic s, input logic u, input logic d,
                       input int n);
        for (int i = 0; i < n; i++)
            step(s, u, d);
    endtask

    initial begin
        reset        = 1'b1;
        currentMode  = 2'd1;
        real_quarter = 1'b1;
        pulsed_set   = 1'b0;
        pulsed_up    = 1'b0;
        pulsed_down  = 1'b0;
        #12;
        chk("rst.state", {14'd0, state}, 16'd0);
        chk_alarm("rst", 0, 0);
        chk_disp("rst", Z, Z, Z, Z);
        @(negedge clk);
        reset = 1'b0;

        // full entry 07:59
        step(1, 0, 0);
        chk("fe.state1", {14'd0, state}, 16'd1);
        chk_disp("fe.h0", Z, Z, Z, Z);
        rep(0, 1, 0, 7);
        chk_disp("fe.h7", Z, SEG[7], Z, Z);
        step(1, 0, 0);
        chk("fe.state2", {14'd0, state}, 16'd2);
        step(0, 0, 1);
        chk_disp("fe.m59", Z, SEG[7], SEG[5], SEG[9]);
        chk_alarm("fe.precommit", 0, 0);
        step(1, 0, 0);
        chk("fe.state0", {14'd0, state}, 16'd0);
        chk_alarm("fe.commit", 7, 59);
        chk_disp("fe.idle", Z, SEG[7], SEG[5], SEG[9]);

        // wrap hours both ways, minutes 59 -> 0
        step(1, 0, 0);
        rep(0, 0, 1, 7);
        chk_disp("wr.h0", Z, Z, SEG[5], SEG[9]);
        step(0, 0, 1);
        chk_disp("wr.h23", SEG[2], SEG[3], SEG[5], SEG[9]);
        step(0, 1, 0);
        chk_disp("wr.h0b", Z, Z, SEG[5], SEG[9]);
        step(1, 0, 0);
        step(0, 1, 0);
        chk_disp("wr.m0", Z, Z, Z, Z);
        chk_alarm("wr.held", 7, 59);
        step(1, 0, 0);
        chk_alarm("wr.commit", 0, 0);

        // commit 06:30
        step(1, 0, 0);
        rep(0, 1, 0, 6);
        step(1, 0, 0);
        rep(0, 1, 0, 30);
        step(1, 0, 0);
        chk_alarm("ab.setup", 6, 30);

        // abort from SET_MIN with work_m = 45
        step(1, 0, 0);
        step(1, 0, 0);
        rep(0, 1, 0, 15);
        chk_disp("ab.m45", Z, SEG[6], SEG[4], SEG[5]);
        currentMode = 2'd0;
        step(0, 0, 0);
        chk("ab.state", {14'd0, state}, 16'd0);
        chk_alarm("ab.kept", 6, 30);
        chk_disp("ab.disp", Z, SEG[6], SEG[3], Z);
        step(1, 0, 0);
        chk("ab.ign.state", {14'd0, state}, 16'd0);
        step(0, 1, 0);
        chk_alarm("ab.ign", 6, 30);

        // mode drop coincident with set in SET_MIN: abort wins
        currentMode = 2'd1;
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        currentMode = 2'd0;
        step(1, 0, 0);
        chk("ab2.state", {14'd0, state}, 16'd0);
        chk_alarm("ab2.kept", 6, 30);
        currentMode = 2'd1;
        step(0, 0, 0);
        chk("reent.state", {14'd0, state}, 16'd0);

        // blink
        step(1, 0, 0);
        real_quarter = 1'b0;
        #1;
        chk_disp("bl.h.dark", BL, BL, SEG[3], Z);
        real_quarter = 1'b1;
        #1;
        chk_disp("bl.h.lit", Z, SEG[6], SEG[3], Z);
        step(1, 0, 0);
        real_quarter = 1'b0;
        #1;
        chk_disp("bl.m.dark", Z, SEG[6], BL, BL);
        real_quarter = 1'b1;
        #1;
        chk_disp("bl.m.lit", Z, SEG[6], SEG[3], Z);
        step(1, 0, 0);
        real_quarter = 1'b0;
        #1;
        chk_disp("bl.idle", Z, SEG[6], SEG[3], Z);
        real_quarter = 1'b1;

        // priority
        step(1, 0, 0);
        step(0, 0, 1);
        chk_disp("pr.h5", Z, SEG[5], SEG[3], Z);
        step(1, 1, 0);
        chk("pr.state", {14'd0, state}, 16'd2);
        chk_disp("pr.hkeep", Z, SEG[5], SEG[3], Z);
        step(0, 1, 1);
        chk_disp("pr.updn", Z, SEG[5], SEG[3], SEG[1]);
        step(1, 0, 0);
        chk_alarm("pr.commit", 5, 31);

        // async reset mid SET_MIN with work_m = 37
        step(1, 0, 0);
        step(1, 0, 0);
        rep(0, 1, 0, 6);
        chk_disp("ar.m37", Z, SEG[5], SEG[3], SEG[7]);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.state", {14'd0, state}, 16'd0);
        chk_alarm("ar", 0, 0);
        chk_disp("ar", Z, Z, Z, Z);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0);
        chk("ar.after", {14'd0, state}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
